// File: rtl/decode_regfile.sv
// Decode-stage integer register file with a per-register pending-write scoreboard.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle writeback data to the read ports.
module decode_regfile #(
  parameter int PEND_W = 2,
  parameter int NREGS  = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2,
  output logic        hazard1,
  output logic        hazard2,
  input  logic        iss_en,
  input  logic [4:0]  iss_reg,
  output logic        iss_stall,
  input  logic [4:0]  wreg,
  input  logic [31:0] wdata,
  input  logic        wen,
  input  logic        kill_en,
  input  logic [4:0]  kill_reg
);

  logic [31:0]       mem_q [NREGS];
  logic [PEND_W-1:0] cnt_q [NREGS];
  logic [PEND_W-1:0] cnt_d [NREGS];
  logic [NREGS-1:0]  underflow;

  logic              wrValid;
  logic              issRelease;
  logic              inc;
  logic              dwb;
  logic              dkill;
  logic [PEND_W:0]   sumInc;
  logic [PEND_W:0]   dec;

  assign wrValid = wen && (wreg != 5'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NREGS; r++) mem_q[r] <= '0;
    end else if (wrValid) begin
      mem_q[wreg] <= wdata;
    end
  end

  // A writeback or kill to the issuing register in the same cycle frees a slot.
  assign issRelease = (wen && (wreg == iss_reg)) || (kill_en && (kill_reg == iss_reg));
  assign iss_stall  = iss_en && (iss_reg != 5'd0) && (&cnt_q[iss_reg]) && !issRelease;

  always_comb begin
    underflow = '0;
    inc       = 1'b0;
    dwb       = 1'b0;
    dkill     = 1'b0;
    sumInc    = '0;
    dec       = '0;
    for (int r = 0; r < NREGS; r++) begin
      cnt_d[r] = cnt_q[r];
      if (r != 0) begin
        inc    = iss_en && (iss_reg == 5'(r)) && !iss_stall;
        dwb    = wen && (wreg == 5'(r));
        dkill  = kill_en && (kill_reg == 5'(r));
        sumInc = {1'b0, cnt_q[r]} + (PEND_W+1)'(inc);
        dec    = (PEND_W+1)'(dwb) + (PEND_W+1)'(dkill);
        // Releasing more writes than were issued clamps at zero.
        if (sumInc < dec) begin
          cnt_d[r]     = '0;
          underflow[r] = 1'b1;
        end else begin
          cnt_d[r] = PEND_W'(sumInc - dec);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NREGS; r++) cnt_q[r] <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic byp1;
  logic byp2;
  assign byp1    = wrValid && (wreg == rs1);
  assign byp2    = wrValid && (wreg == rs2);
  assign rdata1  = byp1 ? wdata : mem_q[rs1];
  assign rdata2  = byp2 ? wdata : mem_q[rs2];
  // The final outstanding write landing now resolves the hazard early.
  assign hazard1 = (rs1 != 5'd0) && (cnt_q[rs1] != '0) &&
                   !(byp1 && (cnt_q[rs1] == PEND_W'(1)));
  assign hazard2 = (rs2 != 5'd0) && (cnt_q[rs2] != '0) &&
                   !(byp2 && (cnt_q[rs2] == PEND_W'(1)));
`else
  assign rdata1  = mem_q[rs1];
  assign rdata2  = mem_q[rs2];
  assign hazard1 = (rs1 != 5'd0) && (cnt_q[rs1] != '0);
  assign hazard2 = (rs2 != 5'd0) && (cnt_q[rs2] != '0);
`endif

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (reset_n) begin
      if (wrValid)
        $strobe("%d: decode_regfile: write x%0d = %08x", $stime, wreg, wdata);
      for (int r = 0; r < NREGS; r++)
        if (underflow[r])
          $display("%d: decode_regfile: protocol violation, pending-count underflow on x%0d",
                   $stime, r);
    end
  end
`endif

endmodule

// File: tb/tb_decode_regfile.sv
// Self-checking bench for decode_regfile: directed scenarios plus randomized traffic
// compared every cycle against an array-based scoreboard model.
module tb_decode_regfile;

  localparam int PEND_W = 2;
  localparam int MAXC   = (1 << PEND_W) - 1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [4:0]  rs1 = '0, rs2 = '0, iss_reg = '0, wreg = '0, kill_reg = '0;
  logic [31:0] wdata = '0;
  logic        iss_en = 1'b0, wen = 1'b0, kill_en = 1'b0;
  logic [31:0] rdata1, rdata2;
  logic        hazard1, hazard2, iss_stall;

  int checks = 0;
  int errors = 0;
  bit cmpEn  = 1'b0;

  logic [31:0] memM [32];
  int          cntM [32];

  decode_regfile #(.PEND_W(PEND_W), .NREGS(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .rs1(rs1), .rs2(rs2), .rdata1(rdata1), .rdata2(rdata2),
    .hazard1(hazard1), .hazard2(hazard2),
    .iss_en(iss_en), .iss_reg(iss_reg), .iss_stall(iss_stall),
    .wreg(wreg), .wdata(wdata), .wen(wen),
    .kill_en(kill_en), .kill_reg(kill_reg)
  );

  always #5 clk = ~clk;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  function automatic bit expStall();
    bit rel;
    rel = (wen && wreg == iss_reg) || (kill_en && kill_reg == iss_reg);
    return iss_en && iss_reg != 0 && cntM[iss_reg] == MAXC && !rel;
  endfunction

  function automatic logic [31:0] expData(input logic [4:0] rs);
    if (rs == 0) return 32'd0;
    if (BYPASS && wen && wreg == rs) return wdata;
    return memM[rs];
  endfunction

  function automatic bit expHaz(input logic [4:0] rs);
    if (rs == 0 || cntM[rs] == 0) return 1'b0;
    if (BYPASS && wen && wreg == rs && cntM[rs] == 1) return 1'b0;
    return 1'b1;
  endfunction

  // Scoreboard model: net counter arithmetic clamped at zero, storage ignoring x0.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < 32; r++) begin
        memM[r] = '0;
        cntM[r] = 0;
      end
    end else begin
      int n;
      bit stall;
      stall = expStall();
      for (int r = 1; r < 32; r++) begin
        n = cntM[r];
        if (iss_en && iss_reg == r && !stall) n++;
        if (wen && wreg == r) n--;
        if (kill_en && kill_reg == r) n--;
        cntM[r] = (n < 0) ? 0 : n;
      end
      if (wen && wreg != 0) memM[wreg] = wdata;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmpEn && reset_n) begin
      checkOutput("cmp_rdata1", rdata1, expData(rs1));
      checkOutput("cmp_rdata2", rdata2, expData(rs2));
      checkOutput("cmp_hazard1", 32'(hazard1), 32'(expHaz(rs1)));
      checkOutput("cmp_hazard2", 32'(hazard2), 32'(expHaz(rs2)));
      checkOutput("cmp_iss_stall", 32'(iss_stall), 32'(expStall()));
    end
  end

  task automatic applyStimulus(input bit ie, input logic [4:0] ir,
                               input bit we, input logic [4:0] wr, input logic [31:0] wd,
                               input bit ke, input logic [4:0] kr,
                               input logic [4:0] r1, input logic [4:0] r2);
    @(posedge clk);
    #1;
    iss_en = ie; iss_reg = ir;
    wen = we; wreg = wr; wdata = wd;
    kill_en = ke; kill_reg = kr;
    rs1 = r1; rs2 = r2;
  endtask

  task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, r1, r2);
  endtask

  initial begin
    int r, k;
    bit we, ke;

    #12 reset_n = 1'b1;
    cmpEn = 1'b1;
    @(negedge clk);
    checkOutput("reset_rdata1", rdata1, 32'd0);
    checkOutput("reset_hazard1", 32'(hazard1), 32'd0);

    // Issue x7, writeback two cycles later.
    applyStimulus(1, 7, 0, 0, 0, 0, 0, 7, 0);
    idle(7, 0);
    @(negedge clk) checkOutput("iw_hazard_c1", 32'(hazard1), 32'd1);
    applyStimulus(0, 0, 1, 7, 32'hDEADBEEF, 0, 0, 7, 0);
    @(negedge clk);
    checkOutput("iw_hazard_wen", 32'(hazard1), BYPASS ? 32'd0 : 32'd1);
    checkOutput("iw_rdata_wen", rdata1, BYPASS ? 32'hDEADBEEF : 32'd0);
    idle(7, 0);
    @(negedge clk);
    checkOutput("iw_hazard_after", 32'(hazard1), 32'd0);
    checkOutput("iw_rdata_after", rdata1, 32'hDEADBEEF);

    // Saturate x3.
    repeat (3) applyStimulus(1, 3, 0, 0, 0, 0, 0, 3, 0);
    applyStimulus(1, 3, 0, 0, 0, 0, 0, 3, 0);
    @(negedge clk) checkOutput("sat_stall", 32'(iss_stall), 32'd1);
    applyStimulus(1, 3, 1, 3, 32'h33, 0, 0, 3, 0);
    @(negedge clk) checkOutput("sat_release_stall", 32'(iss_stall), 32'd0);
    applyStimulus(1, 3, 0, 0, 0, 0, 0, 3, 0);
    @(negedge clk) checkOutput("sat_still_full", 32'(iss_stall), 32'd1);
    repeat (3) applyStimulus(0, 0, 1, 3, 32'h34, 0, 0, 3, 0);
    idle(3, 0);
    @(negedge clk) checkOutput("sat_drained", 32'(hazard1), 32'd0);

    // Simultaneous issue, writeback and kill on x9 with two outstanding.
    repeat (2) applyStimulus(1, 9, 0, 0, 0, 0, 0, 9, 0);
    applyStimulus(1, 9, 1, 9, 32'h99, 1, 9, 9, 0);
    idle(9, 0);
    @(negedge clk) checkOutput("sim_hazard", 32'(hazard1), 32'd1);
    applyStimulus(0, 0, 1, 9, 32'h999, 0, 0, 9, 0);
    @(negedge clk) checkOutput("sim_last_wb", 32'(hazard1), BYPASS ? 32'd0 : 32'd1);
    idle(9, 0);
    @(negedge clk) checkOutput("sim_clear", 32'(hazard1), 32'd0);

    // x0 is hardwired.
    applyStimulus(1, 0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("x0_rdata_wen", rdata1, 32'd0);
    checkOutput("x0_stall", 32'(iss_stall), 32'd0);
    idle(0, 0);
    @(negedge clk);
    checkOutput("x0_rdata", rdata1, 32'd0);
    checkOutput("x0_hazard", 32'(hazard1), 32'd0);

    // Kill with nothing pending on x12 leaves x13 untouched.
    applyStimulus(1, 13, 0, 0, 0, 0, 0, 12, 13);
    applyStimulus(0, 0, 0, 0, 0, 1, 12, 12, 13);
    idle(12, 13);
    @(negedge clk);
    checkOutput("uf_hazard12", 32'(hazard1), 32'd0);
    checkOutput("uf_hazard13", 32'(hazard2), 32'd1);
    applyStimulus(0, 0, 1, 13, 32'h13, 0, 0, 0, 0);

    // Asynchronous reset mid-operation.
    applyStimulus(1, 5, 0, 0, 0, 0, 0, 5, 0);
    applyStimulus(0, 0, 1, 5, 32'h1234, 0, 0, 5, 0);
    repeat (2) applyStimulus(1, 5, 0, 0, 0, 0, 0, 5, 0);
    idle(5, 0);
    @(negedge clk);
    checkOutput("rst_pre_hazard", 32'(hazard1), 32'd1);
    checkOutput("rst_pre_rdata", rdata1, 32'h1234);
    #2;
    reset_n = 1'b0;
    iss_en = 1'b1; iss_reg = 5'd5;
    #1;
    checkOutput("rst_hazard1", 32'(hazard1), 32'd0);
    checkOutput("rst_rdata1", rdata1, 32'd0);
    checkOutput("rst_stall", 32'(iss_stall), 32'd0);
    iss_en = 1'b0;
    @(negedge clk);
    #2 reset_n = 1'b1;

    // Randomized legal traffic.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(posedge clk);
      #1;
      r  = $urandom_range(0, 7);
      we = (r == 0) ? ($urandom % 4 == 0) : (cntM[r] > 0 && ($urandom % 2 == 1));
      k  = $urandom_range(1, 7);
      ke = (cntM[k] > ((we && r == k) ? 1 : 0)) && ($urandom % 4 == 0);
      iss_en   = ($urandom % 3 != 0);
      iss_reg  = 5'($urandom_range(0, 7));
      wen      = we;
      wreg     = 5'(r);
      wdata    = $urandom;
      kill_en  = ke;
      kill_reg = 5'(k);
      rs1      = ($urandom % 8 == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      rs2      = 5'($urandom_range(0, 7));
    end
    idle(0, 0);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
